// File: rtl/gouram_arb_pkg.sv
// gouram_arb_pkg: shared FSM state encoding and timestamp width for signal_query_arbiter.
package gouram_arb_pkg;
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESPOND, ERROR_RESP} arb_state_e;
    localparam int ARB_TS_WIDTH = 32;
endpackage

// File: rtl/signal_query_arbiter_rr_picker.sv
// rr_picker: combinational round-robin priority encoder; first request strictly after i_rr wins.
module rr_picker #(
    parameter int N = 3,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_rr,
    output logic [W-1:0] o_grant,
    output logic         o_any
);
    always_comb begin
        o_grant = '0;
        o_any   = |i_req;
        // Scan farthest-first so the nearest requester after i_rr overwrites last.
        for (int k = N; k >= 1; k--) begin
            if (i_req[(int'(i_rr) + k) % N]) o_grant = W'((int'(i_rr) + k) % N);
        end
    end
endmodule

// File: rtl/signal_query_arbiter.sv
// signal_query_arbiter: shares one signal-history buffer query port between NUM_REQ trackers.
// Optional wait-state timeout enabled by defining ARB_TIMEOUT_EN.
module signal_query_arbiter
    import gouram_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int RESULT_WIDTH   = 32,
    parameter int BUFFER_DEPTH   = 256,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int GW = $clog2(NUM_REQ)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ARB_TS_WIDTH-1:0]         counter,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ARB_TS_WIDTH-1:0] req_time,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [RESULT_WIDTH-1:0]         rsp_data,
    output logic                            rsp_error,
    output logic [GW-1:0]                   grant_id,
    output logic [ARB_TS_WIDTH-1:0]         buf_value_o,
    output logic                            buf_recalc_o,
    input  logic                            buf_data_valid_i,
    input  logic [RESULT_WIDTH-1:0]         buf_result_i
);
    arb_state_e                r_state;
    logic [GW-1:0]             r_rr;
    logic [GW-1:0]             r_grant;
    logic [ARB_TS_WIDTH-1:0]   r_time;
    logic [NUM_REQ-1:0]        r_req_ready;
    logic [NUM_REQ-1:0]        r_rsp_valid;
    logic [RESULT_WIDTH-1:0]   r_result;
    logic [RESULT_WIDTH-1:0]   r_rsp_data;
    logic                      r_rsp_error;
    logic [ARB_TS_WIDTH-1:0]   r_buf_value;
    logic                      r_recalc;
`ifdef ARB_TIMEOUT_EN
    logic [15:0]               r_wait_cnt;
`endif
    logic [GW-1:0]             w_pick;
    logic                      w_any;
    logic signed [ARB_TS_WIDTH-1:0] w_diff;
    logic [ARB_TS_WIDTH-1:0]   w_off;
    logic                      w_oor;

    rr_picker #(.N(NUM_REQ)) u_pick (
        .i_req   (req_valid),
        .i_rr    (r_rr),
        .o_grant (w_pick),
        .o_any   (w_any)
    );

    // Future timestamps clamp to offset 0; offsets past the history depth bypass the buffer.
    assign w_diff = $signed(counter) - $signed(r_time);
    assign w_off  = w_diff[ARB_TS_WIDTH-1] ? '0 : w_diff;
    assign w_oor  = w_off >= ARB_TS_WIDTH'(BUFFER_DEPTH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rr        <= GW'(NUM_REQ - 1);
            r_grant     <= '0;
            r_time      <= '0;
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            r_result    <= '0;
            r_rsp_data  <= '0;
            r_rsp_error <= 1'b0;
            r_buf_value <= '0;
            r_recalc    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_wait_cnt  <= '0;
`endif
        end else begin
            r_req_ready <= '0;
            r_rsp_valid <= '0;
            case (r_state)
                IDLE: if (w_any) begin
                    r_req_ready <= NUM_REQ'(1) << w_pick;
                    r_time      <= req_time[ARB_TS_WIDTH*int'(w_pick) +: ARB_TS_WIDTH];
                    r_grant     <= w_pick;
                    r_state     <= ISSUE;
                end
                ISSUE: begin
`ifdef ARB_TIMEOUT_EN
                    r_wait_cnt <= '0;
`endif
                    if (w_oor) r_state <= ERROR_RESP;
                    else begin
                        r_buf_value <= w_off;
                        r_recalc    <= 1'b1;
                        r_state     <= WAIT;
                    end
                end
                WAIT: if (buf_data_valid_i) begin
                    r_result <= buf_result_i;
                    r_recalc <= 1'b0;
                    r_state  <= RESPOND;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_wait_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                    r_recalc <= 1'b0;
                    r_state  <= ERROR_RESP;
                end else r_wait_cnt <= r_wait_cnt + 16'd1;
`endif
                RESPOND: begin
                    r_rsp_valid <= NUM_REQ'(1) << r_grant;
                    r_rsp_data  <= r_result;
                    r_rsp_error <= 1'b0;
                    r_rr        <= r_grant;
                    r_state     <= IDLE;
                end
                ERROR_RESP: begin
                    r_rsp_valid <= NUM_REQ'(1) << r_grant;
                    r_rsp_data  <= '0;
                    r_rsp_error <= 1'b1;
                    r_rr        <= r_grant;
                    r_state     <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_error    = r_rsp_error;
    assign grant_id     = r_grant;
    assign buf_value_o  = r_buf_value;
    assign buf_recalc_o = r_recalc;
endmodule
